field_packer: RTL and testbench

- Writer side of the 2-bit-field word interface: assembles an 8-bit word X from four 2-bit fields, each written individually at a field selector SEL.
- Field n occupies X[2n+1:2n]; SEL=0 maps to X[1:0] and SEL=3 maps to X[7:6].
- Presents the completed word downstream with a valid/ready handshake to the field-select/compare logic that consumes X.
- Tracks which fields are filled and flags overwrites.

---
 rtl/field_packer_pkg.sv | 9 +
 rtl/field_max.sv | 21 ++
 rtl/field_packer.sv | 93 +++++++++
 tb/tb_field_packer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/field_packer_pkg.sv
// field_packer_pkg: shared constants and state type for the field packer
package field_packer_pkg;
   localparam int FIELD_W = 2;
   localparam int NFIELDS = 4;
   localparam int SEL_W = $clog2(NFIELDS);
   localparam int WORD_W = FIELD_W * NFIELDS;
   localparam logic [NFIELDS-1:0] MASK_FULL = '1;
   typedef enum logic {FILL, FULL} state_t;
endpackage

// File: rtl/field_max.sv
// field_max: largest field of a word and its lowest index (ties go to lower index)
//   w  in  WORD_W  packed word, field n at w[FIELD_W*n +: FIELD_W]
//   mx out FIELD_W maximum field value
//   ix out SEL_W   lowest index holding mx
module field_max
   import field_packer_pkg::*;
(
   input  logic [WORD_W-1:0]  w,
   output logic [FIELD_W-1:0] mx,
   output logic [SEL_W-1:0]   ix
);
   always_comb begin
      mx = w[FIELD_W-1:0];
      ix = '0;
      for (int i = 1; i < NFIELDS; i++)
         if (w[i*FIELD_W +: FIELD_W] > mx) begin
            mx = w[i*FIELD_W +: FIELD_W];
            ix = SEL_W'(i);
         end
   end
endmodule

// File: rtl/field_packer.sv
// field_packer: assembles a word from individually written fields, hands it off via valid/ready
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clr        in   synchronous abort of the partial or held word
//   in_valid   in   field write request;  in_ready out: accepting writes (FILL)
//   sel, d     in   target field index and field data
//   out_valid  out  x holds a complete word; out_ready in: consumer takes it
//   x          out  assembled word;  mask out: fields written this word
//   dup        out  one-cycle pulse after an already-written field is overwritten
//   maxf, maxi out  (FIELD_PACKER_MAX_EN only) max field of the word and its lowest index
module field_packer
   import field_packer_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SEL_W-1:0]   sel,
   input  logic [FIELD_W-1:0] d,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WORD_W-1:0]  x,
   output logic [NFIELDS-1:0] mask,
   output logic               dup
`ifdef FIELD_PACKER_MAX_EN
   ,
   output logic [FIELD_W-1:0] maxf,
   output logic [SEL_W-1:0]   maxi
`endif
);
   state_t state, state_n;
   logic wr, fin;
   logic [NFIELDS-1:0] sel_oh;
   logic [WORD_W-1:0] x_n;

   assign in_ready = state == FILL;
   assign out_valid = state == FULL;
   assign wr = in_valid && in_ready && !clr;
   assign sel_oh = NFIELDS'(1) << sel;
   // the write that fills the last empty field completes the word
   assign fin = wr && ((mask | sel_oh) == MASK_FULL);

   always_comb begin
      x_n = x;
      x_n[sel*FIELD_W +: FIELD_W] = d;
   end

   always_comb
      state_n = clr ? FILL : fin ? FULL : (out_valid && out_ready) ? FILL : state;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= FILL;
      else state <= state_n;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         x <= '0;
         mask <= '0;
         dup <= 1'b0;
      end else if (clr) begin
         x <= '0;
         mask <= '0;
         dup <= 1'b0;
      end else begin
         dup <= wr && mask[sel];
         if (wr) begin
            x <= x_n;
            mask <= mask | sel_oh;
         end else if (out_valid && out_ready)
            mask <= '0;
      end

`ifdef FIELD_PACKER_MAX_EN
   logic [FIELD_W-1:0] mx;
   logic [SEL_W-1:0] ix;

   // evaluated on the word including the completing write
   field_max u_max (.w(x_n), .mx(mx), .ix(ix));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         maxf <= '0;
         maxi <= '0;
      end else if (clr) begin
         maxf <= '0;
         maxi <= '0;
      end else if (fin) begin
         maxf <= mx;
         maxi <= ix;
      end
`endif
endmodule

// File: tb/tb_field_packer.sv
// tb_field_packer: directed table-driven bench for field_packer
module tb_field_packer;
   import field_packer_pkg::*;

   logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [1:0] sel = '0, d = '0;
   logic in_ready, out_valid, dup;
   logic [7:0] x;
   logic [3:0] mask;
   logic [1:0] maxf, maxi;

   always #5 clk = ~clk;

   field_packer dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .d(d), .out_valid(out_valid), .out_ready(out_ready),
      .x(x), .mask(mask), .dup(dup)
`ifdef FIELD_PACKER_MAX_EN
      , .maxf(maxf), .maxi(maxi)
`endif
   );
`ifndef FIELD_PACKER_MAX_EN
   assign maxf = '0;
   assign maxi = '0;
`endif

   typedef struct {
      logic c, iv; logic [1:0] s, dd; logic ordy;
      logic ov, ir; logic [7:0] ex; logic [3:0] em; logic ed; logic [1:0] mf, mi;
   } vec_t;

   vec_t tv[$];
   int checks = 0, fails = 0;

   function automatic vec_t v(logic c, logic iv, logic [1:0] s, logic [1:0] dd, logic ordy,
                              logic ov, logic ir, logic [7:0] ex, logic [3:0] em, logic ed,
                              logic [1:0] mf, logic [1:0] mi);
      vec_t r;
      r.c = c; r.iv = iv; r.s = s; r.dd = dd; r.ordy = ordy;
      r.ov = ov; r.ir = ir; r.ex = ex; r.em = em; r.ed = ed; r.mf = mf; r.mi = mi;
      return r;
   endfunction

   task automatic chk(string n, int act, int exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%0h want=%0h", n, act, exp);
      end
   endtask

   task automatic chk_all(string n, logic ov, logic ir, logic [7:0] ex, logic [3:0] em, logic ed);
      chk({n, ".out_valid"}, int'(out_valid), int'(ov));
      chk({n, ".in_ready"}, int'(in_ready), int'(ir));
      chk({n, ".x"}, int'(x), int'(ex));
      chk({n, ".mask"}, int'(mask), int'(em));
      chk({n, ".dup"}, int'(dup), int'(ed));
   endtask

   task automatic chk_max(string n, logic [1:0] mf, logic [1:0] mi);
`ifdef FIELD_PACKER_MAX_EN
      chk({n, ".maxf"}, int'(maxf), int'(mf));
      chk({n, ".maxi"}, int'(maxi), int'(mi));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(logic [1:0] s, logic [1:0] dd);
      in_valid = 1'b1; sel = s; d = dd;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      // first fill: fields 3,0,2,1 -> 01_10_00_11
      tv.push_back(v(0,1,0,3,0, 0,1,8'h03,4'h1,0, 0,0));
      tv.push_back(v(0,1,1,0,0, 0,1,8'h03,4'h3,0, 0,0));
      tv.push_back(v(0,1,2,2,0, 0,1,8'h23,4'h7,0, 0,0));
      tv.push_back(v(0,1,3,1,0, 1,0,8'h63,4'hF,0, 3,0));
      tv.push_back(v(0,1,1,0,0, 1,0,8'h63,4'hF,0, 3,0));
      tv.push_back(v(0,0,0,0,1, 0,1,8'h63,4'h0,0, 3,0));
      // overwrite of field 2 pulses dup for one cycle
      tv.push_back(v(0,1,2,1,0, 0,1,8'h53,4'h4,0, 3,0));
      tv.push_back(v(0,1,2,3,0, 0,1,8'h73,4'h4,1, 3,0));
      tv.push_back(v(0,0,0,0,0, 0,1,8'h73,4'h4,0, 3,0));
      tv.push_back(v(0,1,0,1,0, 0,1,8'h71,4'h5,0, 3,0));
      tv.push_back(v(0,1,1,2,0, 0,1,8'h79,4'h7,0, 3,0));
      tv.push_back(v(0,1,3,2,0, 1,0,8'hB9,4'hF,0, 3,2));
      tv.push_back(v(0,0,0,0,1, 0,1,8'hB9,4'h0,0, 3,2));
      // three fields then clr with a concurrent write
      tv.push_back(v(0,1,0,1,0, 0,1,8'hB9,4'h1,0, 3,2));
      tv.push_back(v(0,1,1,1,0, 0,1,8'hB5,4'h3,0, 3,2));
      tv.push_back(v(0,1,2,0,0, 0,1,8'h85,4'h7,0, 3,2));
      tv.push_back(v(1,1,3,2,0, 0,1,8'h00,4'h0,0, 0,0));
      // all-equal fields: ties resolve to index 0
      tv.push_back(v(0,1,0,2,0, 0,1,8'h02,4'h1,0, 0,0));
      tv.push_back(v(0,1,1,2,0, 0,1,8'h0A,4'h3,0, 0,0));
      tv.push_back(v(0,1,2,2,0, 0,1,8'h2A,4'h7,0, 0,0));
      tv.push_back(v(0,1,3,2,0, 1,0,8'hAA,4'hF,0, 2,0));
      tv.push_back(v(0,0,0,0,1, 0,1,8'hAA,4'h0,0, 2,0));

      #3;
      chk_all("reset_held", 0, 1, 8'h00, 4'h0, 0);
      chk_max("reset_held", 0, 0);
      #9 rst_n = 1'b1;
      step();
      chk_all("post_reset", 0, 1, 8'h00, 4'h0, 0);

      foreach (tv[i]) begin
         clr = tv[i].c; in_valid = tv[i].iv; sel = tv[i].s; d = tv[i].dd; out_ready = tv[i].ordy;
         step();
         chk_all($sformatf("vec%0d", i), tv[i].ov, tv[i].ir, tv[i].ex, tv[i].em, tv[i].ed);
         chk_max($sformatf("vec%0d", i), tv[i].mf, tv[i].mi);
      end
      clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

      // fields 0,1,2,3 -> 11_10_01_00, then a long hold with ignored writes
      wr(0, 0); wr(1, 1); wr(2, 2); wr(3, 3);
      chk_all("fill_e4", 1, 0, 8'hE4, 4'hF, 0);
      chk_max("fill_e4", 3, 3);
      in_valid = 1'b1; sel = 1; d = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk_all($sformatf("hold%0d", i), 1, 0, 8'hE4, 4'hF, 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk_all("release", 0, 1, 8'hE4, 4'h0, 0);

      // clr wins over a handshake while FULL
      wr(0, 0); wr(1, 1); wr(2, 2); wr(3, 3);
      chk_all("refill", 1, 0, 8'hE4, 4'hF, 0);
      clr = 1'b1; out_ready = 1'b1;
      step();
      clr = 1'b0; out_ready = 1'b0;
      chk_all("clr_full", 0, 1, 8'h00, 4'h0, 0);
      chk_max("clr_full", 0, 0);

      // async reset mid-word, with dup high
      wr(0, 3); wr(0, 1);
      chk_all("pre_rst_dup", 0, 1, 8'h01, 4'h1, 1);
      #2 rst_n = 1'b0;
      #1 chk_all("async_mid", 0, 1, 8'h00, 4'h0, 0);
      #2 rst_n = 1'b1;
      step();

      // async reset while FULL
      wr(0, 1); wr(1, 1); wr(2, 1); wr(3, 1);
      chk_all("fill_55", 1, 0, 8'h55, 4'hF, 0);
      chk_max("fill_55", 1, 0);
      #2 rst_n = 1'b0;
      #1 chk_all("async_full", 0, 1, 8'h00, 4'h0, 0);
      chk_max("async_full", 0, 0);
      #2 rst_n = 1'b1;
      step();
      wr(3, 3); wr(2, 0); wr(1, 3); wr(0, 2);
      chk_all("after_rst", 1, 0, 8'hCE, 4'hF, 0);
      chk_max("after_rst", 3, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
